mult_div_unit: RTL and testbench

Multi-cycle multiply/divide responder with HI/LO registers, sitting beside the ALU in the EX stage. It accepts the EX stage's start request for mult/multu/div/divu/mthi/mtlo and computes the result over a fixed number of cycles. It drives the busy signal that the stall unit combines with its mult-type-instruction decode. It holds HI/LO for mfhi/mflo reads.

---
 rtl/mult_div_unit.sv | 82 ++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/div responder with HI/LO registers beside the EX-stage ALU.
// Results are computed at acceptance and committed to hi/lo on the final busy edge.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic dz_q, dz_d;
   logic done, accept, is_mul, is_div, sgn;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] ua, ub, uq, ur, quot, rem;
   // The completion edge doubles as an acceptance edge so back-to-back ops need no bubble.
   assign done   = state_q == RUN && cnt_q == CW'(1);
   assign accept = start && (state_q == IDLE || done);
   assign is_mul = op == 3'd0 || op == 3'd1;
   assign is_div = op == 3'd2 || op == 3'd3;
   always_comb begin
      ext_a = op == 3'd0 ? {{32{a[31]}}, a} : {32'd0, a};
      ext_b = op == 3'd0 ? {{32{b[31]}}, b} : {32'd0, b};
      prod  = ext_a * ext_b;
      sgn   = op == 3'd2;
      ua    = sgn && a[31] ? -a : a;
      ub    = sgn && b[31] ? -b : b;
      uq    = ub == 32'd0 ? 32'd0 : ua / ub;
      ur    = ub == 32'd0 ? 32'd0 : ua % ub;
      quot  = sgn && (a[31] ^ b[31]) ? -uq : uq;
      rem   = sgn && a[31] ? -ur : ur;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         dz_q     <= dz_d;
      end
   end
   always_comb begin
      state_d = accept && (is_mul || is_div) ? RUN : done ? IDLE : state_q;
   end
   // mthi/mtlo on a completion edge win over the committed result for their register.
   always_comb begin
      cnt_d    = accept && is_mul ? CW'(MULT_CYCLES) :
                 accept && is_div ? CW'(DIV_CYCLES) :
                 state_q == RUN ? cnt_q - CW'(1) : cnt_q;
      res_hi_d = accept && is_mul ? prod[63:32] : accept && is_div ? rem : res_hi_q;
      res_lo_d = accept && is_mul ? prod[31:0] : accept && is_div ? quot : res_lo_q;
      dz_d     = accept && (is_mul || is_div) ? is_div && b == 32'd0 : dz_q;
      hi_d     = accept && op == 3'd4 ? a : done && !dz_q ? res_hi_q : hi_q;
      lo_d     = accept && op == 3'd5 ? a : done && !dz_q ? res_lo_q : lo_q;
   end
   always_comb begin
      busy = state_q == RUN;
      hi   = hi_q;
      lo   = lo_q;
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit; completions are checked by a
// queue-based monitor that counts busy cycles and compares hi/lo at the final edge.
module tb_mult_div_unit;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic busy;
   logic [31:0] hi, lo;
   int n_checks = 0, n_fail = 0;
   typedef struct {
      string name;
      logic [31:0] hi;
      logic [31:0] lo;
      int cyc;
      logic busy_after;
   } exp_t;
   exp_t sb[$];
   int run_cnt = 0;
   logic prev_busy = 1'b0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: each busy edge advances the in-flight op; the last one is its completion.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         sb.delete();
         run_cnt = 0;
         prev_busy = 1'b0;
      end else begin
         if (prev_busy) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL busy_without_op: got busy=1 expected busy=0");
            end else begin
               run_cnt++;
               if (run_cnt == sb[0].cyc) begin
                  check({sb[0].name, "_hi"}, hi, sb[0].hi);
                  check({sb[0].name, "_lo"}, lo, sb[0].lo);
                  check({sb[0].name, "_busy_after"}, 32'(busy), 32'(sb[0].busy_after));
                  void'(sb.pop_front());
                  run_cnt = 0;
               end else if (!busy) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL %s_busy_len: got %0d cycles expected %0d", sb[0].name, run_cnt, sb[0].cyc);
                  void'(sb.pop_front());
                  run_cnt = 0;
               end
            end
         end
         prev_busy = busy;
      end
   end

   task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int cyc, input logic ba);
      exp_t e;
      e.name = name;
      e.hi = eh;
      e.lo = el;
      e.cyc = cyc;
      e.busy_after = ba;
      sb.push_back(e);
      drive(o, x, y);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((sb.size() != 0 || busy) && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k == 60) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #1 reset = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_hi", hi, 32'd0);
      check("idle_lo", lo, 32'd0);
      // Starts during RUN must be dropped, including mtlo.
      issue("mult_3x4_ignored", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0);
      @(negedge clk);
      drive(3'd5, 32'hDEAD, 32'd0);
      check("mtlo_in_run", lo, 32'd0);
      drive(3'd2, 32'd100, 32'd7);
      wait_idle();
      issue("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
      wait_idle();
      issue("multu_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
      wait_idle();
      issue("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
      wait_idle();
      issue("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
      wait_idle();
      drive(3'd4, 32'h1234, 32'd0);
      check("mthi_hi", hi, 32'h1234);
      check("mthi_busy", 32'(busy), 32'd0);
      drive(3'd5, 32'h5678, 32'd0);
      check("mtlo_lo", lo, 32'h5678);
      check("mtlo_busy", 32'(busy), 32'd0);
      issue("div_by_zero", 3'd2, 32'd5, 32'd0, 32'h1234, 32'h5678, 10, 1'b0);
      wait_idle();
      issue("divu_by_zero", 3'd3, 32'd9, 32'd0, 32'h1234, 32'h5678, 10, 1'b0);
      wait_idle();
      issue("div_min_neg1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);
      wait_idle();
      drive(3'd6, 32'h1111, 32'h2222);
      drive(3'd7, 32'h3333, 32'h4444);
      check("noop_hi", hi, 32'd0);
      check("noop_lo", lo, 32'h8000_0000);
      check("noop_busy", 32'(busy), 32'd0);
      // New mult lands on the div completion edge: busy never drops in between.
      issue("div_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1);
      repeat (9) @(negedge clk);
      issue("mult_2x3_b2b", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1'b0);
      wait_idle();
      issue("mult_5x6_mthi", 3'd0, 32'd5, 32'd6, 32'hABCD, 32'd30, 5, 1'b0);
      repeat (4) @(negedge clk);
      drive(3'd4, 32'hABCD, 32'd0);
      wait_idle();
      issue("mult_7x8_aborted", 3'd0, 32'd7, 32'd8, 32'd0, 32'd56, 5, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      #1 reset = 1'b1;
      repeat (8) @(negedge clk);
      check("post_abort_busy", 32'(busy), 32'd0);
      check("post_abort_hi", hi, 32'd0);
      check("post_abort_lo", lo, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected completion within 100000 time units");
      $fatal(1);
   end
endmodule
